// File: rtl/debug_capture_pkg.sv
// rtl/debug_capture_pkg.sv - shared types and constants for the trace capture core
package debug_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4,
        ST_READ  = 3'd5
    } state_t;

    localparam logic [1:0] TRIG_MATCH     = 2'b00;
    localparam logic [1:0] TRIG_ENTRY     = 2'b01;
    localparam logic [1:0] TRIG_CHANGE    = 2'b10;
    localparam logic [1:0] TRIG_IMMEDIATE = 2'b11;

    function automatic int bytes_per_sample(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/debug_capture_ram.sv
// rtl/debug_capture_ram.sv - simple dual-port trace buffer with registered read
module debug_capture_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // No reset on the array or read register so the tools can map this to block SRAM.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/debug_capture.sv
// rtl/debug_capture.sv - probe capture FSM, trigger compare and byte-serial trace readout
module debug_capture
    import debug_capture_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 256,
    parameter int PRE_TRIG = 64
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [WIDTH-1:0] probe_i,
    input  logic             arm_i,
    input  logic [1:0]       trig_mode_i,
    input  logic [WIDTH-1:0] trig_value_i,
    input  logic [WIDTH-1:0] trig_mask_i,
    input  logic             read_start_i,
    output logic [7:0]       rd_data_o,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [2:0]       state_o,
    output logic             triggered_o,
    output logic             done_o
);

    localparam int            AW        = $clog2(DEPTH);
    localparam int            BPS       = bytes_per_sample(WIDTH);
    localparam int            SW        = BPS * 8;
    localparam logic [AW-1:0] PRE_A     = AW'(PRE_TRIG);
    localparam logic [AW-1:0] POST_N    = AW'(DEPTH - PRE_TRIG - 1);
    localparam logic [AW:0]   FETCH_ALL = (AW+1)'(DEPTH);
    localparam logic [2:0]    LAST_BYTE = 3'(BPS - 1);
    localparam state_t        ST_START  = (PRE_TRIG == 0) ? ST_ARMED : ST_FILL;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] probe_q, prev_q, ram_rdata;
    logic             match, prev_match, trig_hit, armed_first;
    logic [AW-1:0]    wr_ptr, trig_addr, fill_cnt, post_cnt, rd_addr, raddr;
    logic [AW:0]      fetch_cnt;
    logic             triggered_q, done_q;
    logic             we, clr, trig_take, start_read, read_end;
    logic             fetch, load, accept, last_byte, ram_vld, out_valid;
    logic [SW-1:0]    out_sample;
    logic [2:0]       byte_cnt;

    assign match = ((probe_q ^ trig_value_i) & trig_mask_i) == '0;

    always_comb begin
        trig_hit = 1'b0;
        case (trig_mode_i)
            TRIG_MATCH:  trig_hit = match;
            TRIG_ENTRY:  trig_hit = match & ~prev_match;
            TRIG_CHANGE: trig_hit = |((probe_q ^ prev_q) & trig_mask_i);
            default:     trig_hit = armed_first;
        endcase
    end

    assign accept    = out_valid & rd_ready_i;
    assign last_byte = (byte_cnt == LAST_BYTE);
    // A fetched sample moves to the output register once the previous sample's last byte is taken.
    assign load      = ram_vld & (~out_valid | (accept & last_byte));
    assign read_end  = (state == ST_READ) & accept & last_byte & ~ram_vld & (fetch_cnt == FETCH_ALL);
    assign fetch     = start_read |
                       ((state == ST_READ) & (fetch_cnt != FETCH_ALL) & (~ram_vld | load));
    assign raddr     = start_read ? (trig_addr - PRE_A) : rd_addr;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        we         = 1'b0;
        clr        = 1'b0;
        trig_take  = 1'b0;
        start_read = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arm_i) begin
                    clr       = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_FILL: begin
                if (arm_i) begin
                    clr       = 1'b1;
                    state_nxt = ST_START;
                end else begin
                    we = 1'b1;
                    if (fill_cnt == PRE_A - 1'b1) state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (arm_i) begin
                    clr       = 1'b1;
                    state_nxt = ST_START;
                end else begin
                    we = 1'b1;
                    if (trig_hit) begin
                        trig_take = 1'b1;
                        state_nxt = (POST_N == '0) ? ST_DONE : ST_POST;
                    end
                end
            end
            ST_POST: begin
                if (arm_i) begin
                    clr       = 1'b1;
                    state_nxt = ST_START;
                end else begin
                    we = 1'b1;
                    if (post_cnt == AW'(1)) state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (arm_i) begin
                    clr       = 1'b1;
                    state_nxt = ST_START;
                end else if (read_start_i) begin
                    start_read = 1'b1;
                    state_nxt  = ST_READ;
                end
            end
            ST_READ: begin
                if (read_end) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            probe_q     <= '0;
            prev_q      <= '0;
            prev_match  <= 1'b0;
            armed_first <= 1'b0;
            wr_ptr      <= '0;
            fill_cnt    <= '0;
            post_cnt    <= '0;
            trig_addr   <= '0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            probe_q     <= probe_i;
            prev_q      <= probe_q;
            prev_match  <= match;
            armed_first <= (state_nxt == ST_ARMED) && ((state != ST_ARMED) || clr);
            if (clr) begin
                wr_ptr      <= '0;
                fill_cnt    <= '0;
                triggered_q <= 1'b0;
                done_q      <= 1'b0;
            end else if (we) begin
                wr_ptr   <= wr_ptr + 1'b1;
                fill_cnt <= fill_cnt + 1'b1;
                if (state_nxt == ST_DONE) done_q <= 1'b1;
            end
            if (trig_take) begin
                trig_addr   <= wr_ptr;
                triggered_q <= 1'b1;
                post_cnt    <= POST_N;
            end else if (we && state == ST_POST) begin
                post_cnt <= post_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_addr    <= '0;
            fetch_cnt  <= '0;
            ram_vld    <= 1'b0;
            out_valid  <= 1'b0;
            out_sample <= '0;
            byte_cnt   <= '0;
        end else begin
            if (fetch) begin
                rd_addr   <= raddr + 1'b1;
                fetch_cnt <= start_read ? (AW+1)'(1) : fetch_cnt + 1'b1;
                ram_vld   <= 1'b1;
            end else if (load) begin
                ram_vld <= 1'b0;
            end
            if (load) begin
                out_sample <= SW'(ram_rdata);
                byte_cnt   <= '0;
                out_valid  <= 1'b1;
            end else if (accept) begin
                if (last_byte) begin
                    out_valid <= 1'b0;
                end else begin
                    out_sample <= out_sample >> 8;
                    byte_cnt   <= byte_cnt + 3'd1;
                end
            end
        end
    end

    debug_capture_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (sys_clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (probe_q),
        .re    (fetch),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    assign rd_data_o   = out_sample[7:0];
    assign rd_valid_o  = out_valid;
    assign state_o     = state;
    assign triggered_o = triggered_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_debug_capture.sv
// tb/tb_debug_capture.sv - self-checking bench for debug_capture across three parameter sets
module tb_debug_capture;

    localparam int DEPTH = 16;
    localparam int K_COUNT = 0, K_ENTRY = 1, K_TOGGLE = 2, K_RAND = 3;

    typedef struct {
        int         inst;
        logic [1:0] mode;
        logic [11:0] val;
        logic [11:0] mask;
        int         kind;
        int         exp_first;
        bit         rnd_ready;
        int         abort_at;
    } scen_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] probe [3];
    logic [11:0] tval  [3];
    logic [11:0] tmask [3];
    logic [1:0]  tmode [3];
    logic [2:0]  arm, rstart, rready, rvalid, trg, dn;
    logic [7:0]  rdata [3];
    logic [2:0]  st    [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    debug_capture #(.WIDTH(8), .DEPTH(DEPTH), .PRE_TRIG(4)) u_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .probe_i(probe[0][7:0]), .arm_i(arm[0]),
        .trig_mode_i(tmode[0]), .trig_value_i(tval[0][7:0]), .trig_mask_i(tmask[0][7:0]),
        .read_start_i(rstart[0]), .rd_data_o(rdata[0]), .rd_valid_o(rvalid[0]),
        .rd_ready_i(rready[0]), .state_o(st[0]), .triggered_o(trg[0]), .done_o(dn[0]));

    debug_capture #(.WIDTH(12), .DEPTH(DEPTH), .PRE_TRIG(4)) u_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .probe_i(probe[1]), .arm_i(arm[1]),
        .trig_mode_i(tmode[1]), .trig_value_i(tval[1]), .trig_mask_i(tmask[1]),
        .read_start_i(rstart[1]), .rd_data_o(rdata[1]), .rd_valid_o(rvalid[1]),
        .rd_ready_i(rready[1]), .state_o(st[1]), .triggered_o(trg[1]), .done_o(dn[1]));

    debug_capture #(.WIDTH(8), .DEPTH(DEPTH), .PRE_TRIG(0)) u_c (
        .sys_clk(clk), .sys_rst_n(rst_n), .probe_i(probe[2][7:0]), .arm_i(arm[2]),
        .trig_mode_i(tmode[2]), .trig_value_i(tval[2][7:0]), .trig_mask_i(tmask[2][7:0]),
        .read_start_i(rstart[2]), .rd_data_o(rdata[2]), .rd_valid_o(rvalid[2]),
        .rd_ready_i(rready[2]), .state_o(st[2]), .triggered_o(trg[2]), .done_o(dn[2]));

    function automatic int iw(input int k);
        return (k == 1) ? 12 : 8;
    endfunction

    function automatic int ipre(input int k);
        return (k == 2) ? 0 : 4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Index of the first trigger-qualified sample; sample j is seq[j+1], seq[0] precedes the arm.
    function automatic int model_trig(input logic [11:0] sq[$], input logic [1:0] mode,
                                      input logic [11:0] val, input logic [11:0] mask,
                                      input int pre, input int w);
        logic [11:0] wm, cur, prv;
        bit m, pm, hit;
        wm = 12'((1 << w) - 1);
        for (int j = pre; j + 1 < sq.size(); j++) begin
            cur = sq[j+1] & wm;
            prv = sq[j] & wm;
            m   = ((cur ^ val) & mask & wm) == 0;
            pm  = ((prv ^ val) & mask & wm) == 0;
            case (mode)
                2'b00:   hit = m;
                2'b01:   hit = m && !pm;
                2'b10:   hit = ((cur ^ prv) & mask & wm) != 0;
                default: hit = (j == pre);
            endcase
            if (hit) return j;
        end
        return -1;
    endfunction

    task automatic build_seq(input scen_t s, output logic [11:0] sq[$]);
        sq = {};
        for (int i = 0; i < 200; i++) begin
            case (s.kind)
                K_COUNT:  sq.push_back(12'(i & 8'hFF));
                K_ENTRY:  sq.push_back((i <= 11 || i == 14) ? 12'h02A :
                                       (i == 12) ? 12'h02B : (i == 13) ? 12'h02C : 12'(8'h80 + i));
                K_TOGGLE: sq.push_back(((i < 20) ? 12'hA00 : 12'hB00) | 12'((i * 7) & 8'hFF));
                default:  sq.push_back(12'($urandom));
            endcase
        end
        if (s.kind == K_RAND && s.mode == 2'b00)
            sq[60] = (sq[60] & ~s.mask) | (s.val & s.mask);
    endtask

    task automatic run_capture(input scen_t s, input logic [11:0] sq[$], input int jt,
                               output bit aborted);
        int k, pre, nrun;
        k   = s.inst;
        pre = ipre(k);
        aborted = 1'b0;
        tmode[k] = s.mode;
        tval[k]  = s.val;
        tmask[k] = s.mask;
        probe[k] = sq[0];
        tick();
        arm[k]   = 1'b1;
        probe[k] = sq[1];
        tick();
        arm[k] = 1'b0;
        check($sformatf("arm_state[%0d]", k), st[k], (pre == 0) ? 3'd2 : 3'd1);
        nrun = jt + DEPTH - pre + 2;
        for (int n = 0; n < nrun; n++) begin
            probe[k] = sq[n+2];
            check($sformatf("triggered[%0d]@%0d", k, n), trg[k], (n >= jt + 1) ? 1 : 0);
            check($sformatf("done[%0d]@%0d", k, n), dn[k], (n >= jt + DEPTH - pre) ? 1 : 0);
            if (n == s.abort_at) begin
                check($sformatf("abort_in_post[%0d]", k), st[k], 3'd3);
                aborted = 1'b1;
                return;
            end
            tick();
        end
        check($sformatf("capture_end_state[%0d]", k), st[k], 3'd4);
    endtask

    task automatic run_read(input int k, input int nbytes, input bit rnd, output logic [7:0] got[$]);
        int  it;
        bit  prev_stall;
        logic [7:0] prev_data;
        got = {};
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        rready[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        rstart[k] = 1'b1;
        tick();
        rstart[k] = 1'b0;
        check($sformatf("read_latency0[%0d]", k), rvalid[k], 0);
        it = 0;
        while (got.size() < nbytes && it < 4000) begin
            if (rnd) rready[k] = 1'($urandom_range(0, 1));
            if (prev_stall) begin
                check($sformatf("stall_valid[%0d]", k), rvalid[k], 1);
                check($sformatf("stall_data[%0d]", k), rdata[k], prev_data);
            end
            if (!rnd && it >= 1) check($sformatf("no_bubble[%0d]@%0d", k, it), rvalid[k], 1);
            if (rvalid[k] && rready[k]) got.push_back(rdata[k]);
            prev_stall = rvalid[k] && !rready[k];
            prev_data  = rdata[k];
            tick();
            it++;
        end
        check($sformatf("read_count[%0d]", k), got.size(), nbytes);
        check($sformatf("read_end_valid[%0d]", k), rvalid[k], 0);
        check($sformatf("read_end_state[%0d]", k), st[k], 3'd4);
        check($sformatf("read_end_done[%0d]", k), dn[k], 1);
    endtask

    scen_t       tbl [7];
    logic [11:0] sq [$];
    logic [7:0]  expb [$];
    logic [7:0]  got1 [$];
    logic [7:0]  got2 [$];

    initial begin
        int k, jt, w, pre, bps, first;
        logic [11:0] samp;
        bit aborted;

        rst_n = 1'b0;
        arm = '0; rstart = '0; rready = '0;
        for (int i = 0; i < 3; i++) begin
            probe[i] = '0; tval[i] = '0; tmask[i] = '0; tmode[i] = '0;
        end

        tbl[0] = '{0, 2'b00, 12'h02A, 12'h0FF, K_COUNT,  12'h026, 1'b0, -1};
        tbl[1] = '{0, 2'b01, 12'h02A, 12'h0FF, K_ENTRY,  12'h02A, 1'b0, -1};
        tbl[2] = '{1, 2'b10, 12'h000, 12'h100, K_TOGGLE, 12'hA70, 1'b0, -1};
        tbl[3] = '{2, 2'b11, 12'h000, 12'h000, K_RAND,   -1,      1'b0, -1};
        tbl[4] = '{0, 2'b00, 12'h005, 12'h00F, K_RAND,   -1,      1'b1, -1};
        tbl[5] = '{0, 2'b00, 12'h02A, 12'h0FF, K_COUNT,  12'h026, 1'b0, 44};
        tbl[6] = '{0, 2'b00, 12'h02A, 12'h0FF, K_COUNT,  12'h026, 1'b1, -1};

        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_state[%0d]", i), st[i], 0);
            check($sformatf("rst_valid[%0d]", i), rvalid[i], 0);
            check($sformatf("rst_data[%0d]", i), rdata[i], 0);
            check($sformatf("rst_trig[%0d]", i), trg[i], 0);
            check($sformatf("rst_done[%0d]", i), dn[i], 0);
        end
        rst_n = 1'b1;
        tick();
        rstart[0] = 1'b1;
        tick();
        rstart[0] = 1'b0;
        check("read_start_in_idle", st[0], 0);

        for (int t = 0; t < 7; t++) begin
            k   = tbl[t].inst;
            w   = iw(k);
            pre = ipre(k);
            bps = (w + 7) / 8;
            build_seq(tbl[t], sq);
            jt = model_trig(sq, tbl[t].mode, tbl[t].val, tbl[t].mask, pre, w);
            run_capture(tbl[t], sq, jt, aborted);
            if (aborted) continue;
            expb = {};
            for (int i = 0; i < DEPTH; i++) begin
                samp = sq[jt - pre + i + 1] & 12'((1 << w) - 1);
                for (int b = 0; b < bps; b++) expb.push_back(8'(samp >> (8 * b)));
            end
            run_read(k, expb.size(), tbl[t].rnd_ready, got1);
            for (int i = 0; i < expb.size() && i < got1.size(); i++)
                check($sformatf("s%0d_byte%0d", t, i), got1[i], expb[i]);
            if (tbl[t].exp_first >= 0 && got1.size() >= bps) begin
                first = (bps == 2) ? (int'(got1[1]) << 8) | int'(got1[0]) : int'(got1[0]);
                check($sformatf("s%0d_first_sample", t), first, tbl[t].exp_first);
            end
            if (tbl[t].rnd_ready) begin
                run_read(k, expb.size(), 1'b1, got2);
                for (int i = 0; i < got1.size() && i < got2.size(); i++)
                    check($sformatf("s%0d_reread%0d", t, i), got2[i], got1[i]);
            end
        end

        rready[0] = 1'b1;
        rstart[0] = 1'b1;
        tick();
        rstart[0] = 1'b0;
        repeat (4) tick();
        check("mid_read_valid", rvalid[0], 1);
        check("mid_read_state", st[0], 5);
        #2 rst_n = 1'b0;
        #1;
        check("rst_read_state", st[0], 0);
        check("rst_read_valid", rvalid[0], 0);
        check("rst_read_data", rdata[0], 0);
        check("rst_read_trig", trg[0], 0);
        check("rst_read_done", dn[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_state", st[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
